seq_div16: RTL
==============

Name: seq_div16

Overview:
Multi-cycle unsigned restoring divider for the 16-bit datapath. It is the inverse-direction companion to the single-cycle saturating add/sub unit. The decode/execute stage issues a divide with a start pulse and stalls on busy. The block returns quotient and remainder after a fixed iteration count, or immediately on divide-by-zero.

Parameters:
WIDTH, 16, operand/result width; iteration count equals WIDTH.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when state is IDLE or DONE
dividend  input  WIDTH  numerator, captured on accepted start
divisor  input  WIDTH  denominator, captured on accepted start
busy  output  1  high while an operation is in progress (state RUN)
done  output  1  one-cycle pulse: quotient/remainder/dz valid
quotient  output  WIDTH  result quotient, held until next accepted start
remainder  output  WIDTH  result remainder, held until next accepted start
dz  output  1  divide-by-zero flag for the last completed operation

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, dz=0, quotient=0, remainder=0; iteration counter=0. Reset asserted mid-RUN aborts the operation, and no done is issued.
- States:
  - IDLE: waiting for a request.
  - RUN: iterating.
  - DONE: done=1 for exactly one cycle.
- Transitions:
  - IDLE --start, divisor!=0--> RUN.
  - IDLE --start, divisor==0--> DONE.
  - RUN --counter==WIDTH-1 at edge--> DONE.
  - DONE --start--> same as from IDLE (back-to-back issue).
  - DONE --no start--> IDLE.
- Accept edge (edge 0):
  - Latch divisor; load quotient register with dividend; clear partial remainder; counter=0; dz=0.
  - Divide-by-zero: quotient=all ones (0xFFFF), remainder=dividend, dz=1; go directly to DONE. done is visible in the cycle after edge 0.
- Iteration (edges 1..WIDTH in RUN):
  - Shift {rem,quo} left by 1.
  - Trial = rem_shifted - divisor at WIDTH+1 bits, non-saturating.
  - No borrow: rem=trial, quo LSB=1.
  - Borrow: rem unchanged (restore), quo LSB=0.
  - Increment counter.
- Latency: done rises after edge WIDTH (16) following the accept edge, i.e. the result is visible 16 cycles after the start edge.
- busy=1 from the accept edge until the DONE transition; busy=0 in IDLE and DONE.
- start while RUN: ignored; operands are not re-sampled and the running operation is unaffected.
- Outputs quotient/remainder/dz hold their last values in IDLE. Intermediate values are visible during RUN, but consumers must only sample on done.
- Arithmetic never saturates; the trial subtract must use a borrow-out, not an overflow-clamped sum.
- Boundaries:
  - dividend < divisor: q=0, r=dividend.
  - divisor=1: q=dividend, r=0.
  - dividend=0: q=0, r=0 after the full 16 cycles.

Decomposition:
- Shared package: state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10); constant DIV_ZERO_Q = all ones; WIDTH default.
- Sub-module div_trial_sub:
  - Combinational (WIDTH+1)-bit subtract.
  - Inputs: shifted remainder, divisor.
  - Outputs: difference[WIDTH-1:0], borrow.
- The FSM, counter and shift registers live in seq_div16.

Test Plan:
- 100/7 (0x0064/0x0007), start at edge 0 -> busy high for 16 cycles; done pulse after edge 16 with q=0x000E, r=0x0002, dz=0; done low the next cycle.
- 0xFFFF/0x0001 -> q=0xFFFF, r=0x0000; 0x0003/0x000A -> q=0x0000, r=0x0003; 0x8000/0x0003 -> q=0x2AAA, r=0x0002.
- 0x0005/0x0000 -> done one cycle after start, q=0xFFFF, r=0x0005, dz=1, busy never high.
- Start 100/7, then assert start with 9/3 at cycle 5 -> second request ignored; result is still q=0x000E, r=0x0002 at cycle 16.
- Start 100/7, pull rst_n low at cycle 8 asynchronously -> all outputs 0 immediately, no done; after release, 9/3 -> q=0x0003, r=0x0000.
- Start 100/7, then assert start with 20/6 in the DONE cycle -> accepted back-to-back; second done after 16 more cycles with q=0x0003, r=0x0002.

Source files
------------

// File: rtl/seq_div16_pkg.sv
// Purpose : shared types and constants for the sequential restoring divider.
// Latency : n/a (declarations only).
// Backpressure : n/a.
package seq_div16_pkg;

  // Default operand/result width; also the number of iterations per divide.
  localparam int DIV_WIDTH = 16;

  // Quotient reported on divide-by-zero: all ones.
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } div_state_e;

endpackage : seq_div16_pkg

// File: rtl/seq_div16_if.sv
// Purpose : request/result bundle between the issuing stage and the divider.
// Latency : n/a (wiring only).
// Backpressure : issuer holds off while busy; start is ignored during a run.
//
// Signals:
//   start     - request strobe, sampled only when the divider is idle or done
//   dividend  - numerator, captured on an accepted start
//   divisor   - denominator, captured on an accepted start
//   busy      - high while iterating
//   done      - one-cycle pulse, quotient/remainder/dz valid
//   quotient  - result quotient, held until the next accepted start
//   remainder - result remainder, held until the next accepted start
//   dz        - divide-by-zero flag of the last completed operation
interface seq_div16_if
  import seq_div16_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             dz;

  // Issuing side.
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, dz
  );

  // Divider side.
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, dz
  );

endinterface : seq_div16_if

// File: rtl/seq_div16_trial_sub.sv
// Purpose : trial subtract of one restoring-division step (shifted remainder - divisor).
// Latency : combinational.
// Backpressure : none.
//
// Ports:
//   rem_shift - partial remainder after the left shift, WIDTH+1 bits
//   divisor   - latched divisor
//   diff      - low WIDTH bits of the difference (meaningful when borrow=0)
//   borrow    - borrow-out; 1 means divisor does not fit and the step restores
module div_trial_sub
  import seq_div16_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_shift,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  // One extra bit above the WIDTH+1 operands carries the borrow-out.
  logic [WIDTH+1:0] full_diff;
  // The remainder always stays below the divisor, so the shifted value is
  // below 2*divisor and a non-borrowing difference fits in WIDTH bits;
  // bit WIDTH is therefore always zero when it matters.
  logic             diff_msb_unused;

  assign full_diff       = {1'b0, rem_shift} - {2'b00, divisor};
  assign borrow          = full_diff[WIDTH+1];
  assign diff            = full_diff[WIDTH-1:0];
  assign diff_msb_unused = full_diff[WIDTH];

endmodule : div_trial_sub

// File: rtl/seq_div16.sv
// Purpose : multi-cycle unsigned restoring divider, one quotient bit per cycle.
// Latency : done pulses WIDTH cycles after the accept edge; 1 cycle on divide-by-zero.
// Backpressure : busy high while running; start during a run is ignored.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset (aborts a run, no done issued)
//   bus   - slave side of seq_div16_if (start/operands in, busy/done/results out)
module seq_div16
  import seq_div16_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_div16_if.slave   bus
);

  // Counter must reach WIDTH after the final increment.
  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] trial_diff;
  logic             trial_borrow;

  // {rem,quo} shifted left by one: the quotient MSB moves into the remainder.
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};

  div_trial_sub #(.WIDTH(WIDTH)) u_trial (
    .rem_shift (rem_shift),
    .divisor   (dvsr_q),
    .diff      (trial_diff),
    .borrow    (trial_borrow)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvsr_d  = dvsr_q;
    dz_d    = dz_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // DONE always falls back to IDLE unless a new request arrives.
        state_d = ST_IDLE;
        if (bus.start) begin
          dvsr_d = bus.divisor;
          cnt_d  = '0;
          if (bus.divisor == '0) begin
            quo_d   = DIV_ZERO_Q;
            rem_d   = bus.dividend;
            dz_d    = 1'b1;
            state_d = ST_DONE;
          end else begin
            quo_d   = bus.dividend;
            rem_d   = '0;
            dz_d    = 1'b0;
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        // Restore on borrow: keep the shifted remainder (it fits in WIDTH
        // bits because it is below the divisor in that case).
        quo_d = {quo_q[WIDTH-2:0], ~trial_borrow};
        rem_d = trial_borrow ? rem_shift[WIDTH-1:0] : trial_diff;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_DONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Status outputs are registered versions of the next state.
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvsr_q  <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvsr_q  <= dvsr_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.dz        = dz_q;

endmodule : seq_div16
